// File: rtl/hex_scan_ctrl.sv
// rtl/hex_scan_ctrl.sv - time-shares one external 7-segment encoder across NDIG hex digits
// Optional ENC_PIPE_EN: registers the encoder result before capture (two cycles per digit).
module hex_scan_ctrl #(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [4*NDIG-1:0] ld_data,
  input  logic [NDIG-1:0]   ld_neg,
  output logic [3:0]        enc_x,
  output logic              enc_neg,
  input  logic [6:0]        enc_seg,
  input  logic              enc_negsign,
  output logic [7*NDIG-1:0] hex_seg,
  output logic [NDIG-1:0]   hex_sign,
  output logic              done
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WAIT} state_t;

  state_t            state, state_nxt;
  logic [IW-1:0]     idx, idx_nxt;
  logic [4*NDIG-1:0] ld_d;
  logic [NDIG-1:0]   ld_n;
  logic [7*NDIG-1:0] shadow_seg, shadow_seg_nxt;
  logic [NDIG-1:0]   shadow_sign, shadow_sign_nxt;
  logic              last;
  logic              cap_en;
  logic [6:0]        cap_seg;
  logic              cap_sign;

  assign last     = (idx == IW'(NDIG - 1));
  assign ld_ready = (state == S_IDLE);

`ifdef ENC_PIPE_EN
  logic [6:0] pipe_seg;
  logic       pipe_sign;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_seg  <= '1;
      pipe_sign <= 1'b1;
    end else if (state == S_SCAN) begin
      pipe_seg  <= enc_seg;
      pipe_sign <= enc_negsign;
    end
  end

  assign cap_en   = (state == S_WAIT);
  assign cap_seg  = pipe_seg;
  assign cap_sign = pipe_sign;
`else
  assign cap_en   = (state == S_SCAN);
  assign cap_seg  = enc_seg;
  assign cap_sign = enc_negsign;
`endif

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      S_IDLE: begin
        if (ld_valid) begin
          state_nxt = S_SCAN;
          idx_nxt   = '0;
        end
      end
      S_SCAN: begin
`ifdef ENC_PIPE_EN
        state_nxt = S_WAIT;
`else
        if (last) begin
          state_nxt = S_IDLE;
        end else begin
          idx_nxt = idx + IW'(1);
        end
`endif
      end
`ifdef ENC_PIPE_EN
      S_WAIT: begin
        if (last) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_SCAN;
          idx_nxt   = idx + IW'(1);
        end
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // The digit captured on the commit edge is merged in here so the commit sees the full frame.
  always_comb begin
    shadow_seg_nxt  = shadow_seg;
    shadow_sign_nxt = shadow_sign;
    if (cap_en) begin
      shadow_seg_nxt[7*int'(idx) +: 7] = cap_seg;
      shadow_sign_nxt[idx]             = cap_sign;
    end
  end

  always_comb begin
    enc_x   = 4'h0;
    enc_neg = 1'b0;
    if (state != S_IDLE) begin
      enc_x   = ld_d[4*int'(idx) +: 4];
      enc_neg = ld_n[idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      ld_d        <= '0;
      ld_n        <= '0;
      shadow_seg  <= '1;
      shadow_sign <= '1;
      hex_seg     <= '1;
      hex_sign    <= '1;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      shadow_seg  <= shadow_seg_nxt;
      shadow_sign <= shadow_sign_nxt;
      done        <= cap_en && last;
      if (ld_valid && ld_ready) begin
        ld_d <= ld_data;
        ld_n <= ld_neg;
      end
      if (cap_en && last) begin
        hex_seg  <= shadow_seg_nxt;
        hex_sign <= shadow_sign_nxt;
      end
    end
  end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// tb/tb_hex_scan_ctrl.sv - directed self-checking bench for hex_scan_ctrl (NDIG=4 and NDIG=1)
module tb_hex_scan_ctrl;

`ifdef ENC_PIPE_EN
  localparam int CPD = 2;
`else
  localparam int CPD = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [15:0] ld_data = '0;
  logic [3:0]  ld_neg = '0;
  logic [3:0]  enc_x;
  logic        enc_neg;
  logic [6:0]  enc_seg;
  logic        enc_negsign;
  logic [27:0] hex_seg;
  logic [3:0]  hex_sign;
  logic        done;

  logic        ld_valid1 = 1'b0;
  logic        ld_ready1;
  logic [3:0]  ld_data1 = '0;
  logic        ld_neg1 = 1'b0;
  logic [3:0]  enc_x1;
  logic        enc_neg1;
  logic [6:0]  enc_seg1;
  logic        enc_negsign1;
  logic [6:0]  hex_seg1;
  logic        hex_sign1;
  logic        done1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Reference two's-complement encoder: {negsign, seg}, both active-low.
  function automatic logic [7:0] enc7(input logic [3:0] x, input logic neg);
    logic [3:0] mag;
    logic [6:0] s;
    mag = (neg && x[3]) ? (4'h0 - x) : x;
    case (mag)
      4'h0: s = 7'h40; 4'h1: s = 7'h79; 4'h2: s = 7'h24; 4'h3: s = 7'h30;
      4'h4: s = 7'h19; 4'h5: s = 7'h12; 4'h6: s = 7'h02; 4'h7: s = 7'h78;
      4'h8: s = 7'h00; 4'h9: s = 7'h10; 4'hA: s = 7'h08; 4'hB: s = 7'h03;
      4'hC: s = 7'h46; 4'hD: s = 7'h21; 4'hE: s = 7'h06; default: s = 7'h0E;
    endcase
    return {~(neg && x[3]), s};
  endfunction

  function automatic logic [31:0] frame_model(input logic [15:0] d, input logic [3:0] n);
    logic [27:0] seg;
    logic [3:0]  sg;
    logic [7:0]  e;
    for (int i = 0; i < 4; i++) begin
      e = enc7(d[4*i +: 4], n[i]);
      seg[7*i +: 7] = e[6:0];
      sg[i] = e[7];
    end
    return {sg, seg};
  endfunction

  assign {enc_negsign, enc_seg}   = enc7(enc_x, enc_neg);
  assign {enc_negsign1, enc_seg1} = enc7(enc_x1, enc_neg1);

  hex_scan_ctrl #(.NDIG(4)) u_dut4 (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_neg(ld_neg), .enc_x(enc_x), .enc_neg(enc_neg),
    .enc_seg(enc_seg), .enc_negsign(enc_negsign), .hex_seg(hex_seg),
    .hex_sign(hex_sign), .done(done)
  );

  hex_scan_ctrl #(.NDIG(1)) u_dut1 (
    .clk(clk), .rst(rst), .ld_valid(ld_valid1), .ld_ready(ld_ready1),
    .ld_data(ld_data1), .ld_neg(ld_neg1), .enc_x(enc_x1), .enc_neg(enc_neg1),
    .enc_seg(enc_seg1), .enc_negsign(enc_negsign1), .hex_seg(hex_seg1),
    .hex_sign(hex_sign1), .done(done1)
  );

  // Accepts one frame on u_dut4, scrambles inputs after the accept edge, returns edges until done.
  task automatic do_frame(input logic [15:0] d, input logic [3:0] n, output int lat);
    @(negedge clk);
    ld_data = d; ld_neg = n; ld_valid = 1'b1;
    tests++;
    if (ld_ready !== 1'b1) begin fails++; $display("FAIL ld_ready_pre: got %b want 1", ld_ready); end
    @(posedge clk); #1;
    ld_valid = 1'b0; ld_data = ~d; ld_neg = ~n;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      if (done === 1'b1) break;
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (hex_seg !== 28'hFFFFFFF || hex_sign !== 4'hF) begin
      fails++; $display("FAIL reset_in: hex_seg=%h hex_sign=%h want FFFFFFF F", hex_seg, hex_sign);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (hex_seg !== 28'hFFFFFFF || hex_sign !== 4'hF || ld_ready !== 1'b1 || done !== 1'b0) begin
      fails++; $display("FAIL reset_out: seg=%h sign=%h rdy=%b done=%b want FFFFFFF F 1 0",
                        hex_seg, hex_sign, ld_ready, done);
    end
    tests++;
    if (enc_x !== 4'h0 || enc_neg !== 1'b0 || hex_seg1 !== 7'h7F || hex_sign1 !== 1'b1 || ld_ready1 !== 1'b1) begin
      fails++; $display("FAIL reset_enc: enc_x=%h enc_neg=%b seg1=%h sign1=%b rdy1=%b",
                        enc_x, enc_neg, hex_seg1, hex_sign1, ld_ready1);
    end
  endtask

  task automatic test_zero;
    int lat;
    do_frame(16'h0000, 4'h0, lat);
    tests++;
    if (lat !== 4*CPD) begin fails++; $display("FAIL zero_latency: got %0d want %0d", lat, 4*CPD); end
    tests++;
    if (hex_seg !== {4{7'h40}} || hex_sign !== 4'hF) begin
      fails++; $display("FAIL zero_frame: seg=%h sign=%h want %h F", hex_seg, hex_sign, {4{7'h40}});
    end
    tests++;
    if (ld_ready !== 1'b1) begin fails++; $display("FAIL zero_ready: got %b want 1", ld_ready); end
    @(negedge clk);
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL zero_done_once: got %b want 0", done); end
  endtask

  task automatic test_neg;
    int lat;
    @(negedge clk);
    ld_data = 16'hF0F0; ld_neg = 4'b1010; ld_valid = 1'b1;
    @(posedge clk); #1;
    ld_valid = 1'b0; ld_data = 16'h0F0F; ld_neg = 4'b0101;
    repeat (CPD) @(posedge clk);
    @(negedge clk);
    tests++;
    if (enc_x !== 4'hF || enc_neg !== 1'b1) begin
      fails++; $display("FAIL neg_enc_digit1: enc_x=%h enc_neg=%b want F 1", enc_x, enc_neg);
    end
    lat = CPD;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done === 1'b1) break;
    end
    tests++;
    if (lat !== 4*CPD) begin fails++; $display("FAIL neg_latency: got %0d want %0d", lat, 4*CPD); end
    tests++;
    if (hex_seg !== {7'h79, 7'h40, 7'h79, 7'h40} || hex_sign !== 4'b0101) begin
      fails++; $display("FAIL neg_frame: seg=%h sign=%b want %h 0101",
                        hex_seg, hex_sign, {7'h79, 7'h40, 7'h79, 7'h40});
    end
    tests++;
    if (enc_x !== 4'h0 || enc_neg !== 1'b0) begin
      fails++; $display("FAIL neg_idle_enc: enc_x=%h enc_neg=%b want 0 0", enc_x, enc_neg);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] qd[$];
    logic [3:0]  qn[$];
    logic [27:0] prev_seg;
    logic [31:0] exp;
    logic [15:0] d;
    logic [3:0]  n;
    int accepts = 0;
    int commits = 0;
    int per = 4*CPD + 1;
    @(negedge clk);
    prev_seg = hex_seg;
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1) begin
        commits++;
        tests++;
        if (qd.size() == 0) begin
          fails++; $display("FAIL b2b_spurious_commit: cycle %0d", c);
        end else begin
          d = qd.pop_front(); n = qn.pop_front();
          exp = frame_model(d, n);
          if (hex_seg !== exp[27:0] || hex_sign !== exp[31:28]) begin
            fails++; $display("FAIL b2b_frame: d=%h n=%b seg=%h sign=%b want %h %b",
                              d, n, hex_seg, hex_sign, exp[27:0], exp[31:28]);
          end
        end
      end else if (hex_seg !== prev_seg) begin
        tests++; fails++;
        $display("FAIL b2b_stable: cycle %0d seg=%h was %h without done", c, hex_seg, prev_seg);
      end
      prev_seg = hex_seg;
      ld_valid = (c < 20);
      ld_data  = 16'(32'h9E37 * (c + 3));
      ld_neg   = 4'(c * 5);
      if (ld_valid && ld_ready === 1'b1) begin
        accepts++;
        qd.push_back(ld_data);
        qn.push_back(ld_neg);
      end
      @(posedge clk);
      @(negedge clk);
    end
    ld_valid = 1'b0;
    tests++;
    if (accepts !== (20 + per - 1) / per) begin
      fails++; $display("FAIL b2b_accepts: got %0d want %0d", accepts, (20 + per - 1) / per);
    end
    tests++;
    if (commits !== accepts) begin fails++; $display("FAIL b2b_commits: got %0d want %0d", commits, accepts); end
  endtask

  task automatic test_reset_mid_scan;
    int done_seen = 0;
    @(negedge clk);
    ld_data = 16'h1234; ld_neg = 4'h0; ld_valid = 1'b1;
    @(posedge clk); #1;
    ld_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    tests++;
    if (hex_seg !== 28'hFFFFFFF || hex_sign !== 4'hF || done !== 1'b0) begin
      fails++; $display("FAIL midrst_blank: seg=%h sign=%h done=%b want FFFFFFF F 0", hex_seg, hex_sign, done);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    tests++;
    if (done_seen !== 0 || ld_ready !== 1'b1 || hex_seg !== 28'hFFFFFFF) begin
      fails++; $display("FAIL midrst_after: done_seen=%0d rdy=%b seg=%h want 0 1 FFFFFFF",
                        done_seen, ld_ready, hex_seg);
    end
  endtask

  task automatic test_ndig1;
    int lat = 0;
    @(negedge clk);
    ld_data1 = 4'h8; ld_neg1 = 1'b1; ld_valid1 = 1'b1;
    @(posedge clk); #1;
    ld_valid1 = 1'b0; ld_data1 = 4'h0; ld_neg1 = 1'b0;
    while (lat < 40) begin
      @(negedge clk);
      if (done1 === 1'b1) break;
      @(posedge clk);
      lat++;
    end
    tests++;
    if (lat !== CPD) begin fails++; $display("FAIL ndig1_latency: got %0d want %0d", lat, CPD); end
    tests++;
    if (hex_seg1 !== 7'h00 || hex_sign1 !== 1'b0) begin
      fails++; $display("FAIL ndig1_frame: seg=%h sign=%b want 00 0", hex_seg1, hex_sign1);
    end
  endtask

  initial begin
    test_reset;
    test_zero;
    test_neg;
    test_back_to_back;
    test_reset_mid_scan;
    test_ndig1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
